// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime behind a
// zero-latency memory-mapped port, driving MTIP/MSIP into the trap logic.
module clint #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [XLEN-1:0]            i_addr,
    input  logic [XLEN-1:0]            i_wdata,
    input  logic [XLEN/BYTE_WIDTH-1:0] i_wstrb,
    input  logic                       i_we,
    output logic [XLEN-1:0]            o_rdata,
    output logic [63:0]                o_mtime,
    output logic                       o_irq_timer,
    output logic                       o_irq_soft
);
    localparam int unsigned NB = XLEN / BYTE_WIDTH;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [XLEN-1:0] ADDR_MSIP   = XLEN'(32'h0000);
    localparam logic [XLEN-1:0] ADDR_CMP_LO = XLEN'(32'h4000);
    localparam logic [XLEN-1:0] ADDR_CMP_HI = XLEN'(32'h4004);
    localparam logic [XLEN-1:0] ADDR_MT_LO  = XLEN'(32'hBFF8);
    localparam logic [XLEN-1:0] ADDR_MT_HI  = XLEN'(32'hBFFC);

    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_msip;
    logic          r_irq_timer;
    logic [CW-1:0] r_cnt;

    logic [XLEN-1:0] w_off;
    logic            w_tick;
    logic            w_we_msip, w_we_cmp_lo, w_we_cmp_hi, w_we_mt_lo, w_we_mt_hi;
    logic            w_unused_addr;

    // Word-aligned offset; the two byte-offset bits never participate in decode.
    assign w_off         = {i_addr[XLEN-1:2], 2'b00};
    assign w_unused_addr = ^i_addr[1:0];

    assign w_tick      = (r_cnt == CW'(TICK_DIV - 1));
    assign w_we_msip   = i_we && (w_off == ADDR_MSIP);
    assign w_we_cmp_lo = i_we && (w_off == ADDR_CMP_LO);
    assign w_we_cmp_hi = i_we && (w_off == ADDR_CMP_HI);
    assign w_we_mt_lo  = i_we && (w_off == ADDR_MT_LO);
    assign w_we_mt_hi  = i_we && (w_off == ADDR_MT_HI);

    function automatic logic [31:0] merge(input logic [31:0]      old,
                                          input logic [XLEN-1:0] data,
                                          input logic [NB-1:0]   strb);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtime     <= '0;
            r_mtimecmp  <= MTIMECMP_RST;
            r_msip      <= 1'b0;
            r_irq_timer <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_irq_timer <= (r_mtime >= r_mtimecmp);
            r_cnt       <= w_tick ? '0 : r_cnt + CW'(1);

            // A write to either mtime word suppresses this cycle's increment.
            if (w_we_mt_lo) begin
                r_mtime <= {r_mtime[63:32], merge(r_mtime[31:0], i_wdata, i_wstrb)};
            end else if (w_we_mt_hi) begin
                r_mtime <= {merge(r_mtime[63:32], i_wdata, i_wstrb), r_mtime[31:0]};
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_we_cmp_lo) begin
                r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], i_wdata, i_wstrb);
            end
            if (w_we_cmp_hi) begin
                r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], i_wdata, i_wstrb);
            end
            if (w_we_msip && i_wstrb[0]) begin
                r_msip <= i_wdata[0];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (w_off)
            ADDR_MSIP:   o_rdata = XLEN'(r_msip);
            ADDR_CMP_LO: o_rdata = XLEN'(r_mtimecmp[31:0]);
            ADDR_CMP_HI: o_rdata = XLEN'(r_mtimecmp[63:32]);
            ADDR_MT_LO:  o_rdata = XLEN'(r_mtime[31:0]);
            ADDR_MT_HI:  o_rdata = XLEN'(r_mtime[63:32]);
            default:     o_rdata = '0;
        endcase
    end

    assign o_mtime     = r_mtime;
    assign o_irq_timer = r_irq_timer;
    assign o_irq_soft  = r_msip;
endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV=1 and 4) driven by shared stimulus and
// checked every cycle against a behavioural model, plus literal directed checks.
module tb_clint;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        we;

    logic [31:0] rdata0, rdata1;
    logic [63:0] mtime0, mtime1;
    logic        irqt0, irqt1, irqs0, irqs1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    clint #(.TICK_DIV(1)) u_div1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
        .i_we(we), .o_rdata(rdata0), .o_mtime(mtime0), .o_irq_timer(irqt0),
        .o_irq_soft(irqs0)
    );

    clint #(.TICK_DIV(4)) u_div4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
        .i_we(we), .o_rdata(rdata1), .o_mtime(mtime1), .o_irq_timer(irqt1),
        .o_irq_soft(irqs1)
    );

    // Behavioural model: index 0 is TICK_DIV=1, index 1 is TICK_DIV=4.
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_irq   [2];
    longint      m_cyc   [2];
    bit          m_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'h0000: return {31'd0, m_msip[i]};
            32'h4000: return m_cmp[i][31:0];
            32'h4004: return m_cmp[i][63:32];
            32'hBFF8: return m_mtime[i][31:0];
            32'hBFFC: return m_mtime[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        longint      div;
        logic [31:0] w;
        bit          tick;
        w = {addr[31:2], 2'b00};
        for (int i = 0; i < 2; i++) begin
            div = (i == 0) ? 1 : 4;
            if (!rst_n) begin
                m_mtime[i] = 64'd0;
                m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[i]  = 1'b0;
                m_irq[i]   = 1'b0;
                m_cyc[i]   = 0;
            end else if (m_valid) begin
                m_irq[i] = (m_mtime[i] >= m_cmp[i]);
                tick     = ((m_cyc[i] % div) == div - 1);
                m_cyc[i]++;
                if (we && w == 32'hBFF8)      m_mtime[i][31:0]  = mrg(m_mtime[i][31:0], wdata, wstrb);
                else if (we && w == 32'hBFFC) m_mtime[i][63:32] = mrg(m_mtime[i][63:32], wdata, wstrb);
                else if (tick)                m_mtime[i] = m_mtime[i] + 64'd1;
                if (we && w == 32'h4000) m_cmp[i][31:0]  = mrg(m_cmp[i][31:0], wdata, wstrb);
                if (we && w == 32'h4004) m_cmp[i][63:32] = mrg(m_cmp[i][63:32], wdata, wstrb);
                if (we && w == 32'h0000 && wstrb[0]) m_msip[i] = wdata[0];
            end
        end
        if (!rst_n) m_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("rdata_div1", {32'd0, rdata0}, {32'd0, m_read(0, addr)});
            check("rdata_div4", {32'd0, rdata1}, {32'd0, m_read(1, addr)});
            check("mtime_div1", mtime0, m_mtime[0]);
            check("mtime_div4", mtime1, m_mtime[1]);
            check("irq_timer_div1", {63'd0, irqt0}, {63'd0, m_irq[0]});
            check("irq_timer_div4", {63'd0, irqt1}, {63'd0, m_irq[1]});
            check("irq_soft_div1", {63'd0, irqs0}, {63'd0, m_msip[0]});
            check("irq_soft_div4", {63'd0, irqs1}, {63'd0, m_msip[1]});
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic e);
        addr = a; wdata = d; wstrb = s; we = e;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [31:0] tbl [8];
    int          n;

    initial begin
        tbl = '{32'h0000, 32'h0004, 32'h0008, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC,
                32'h1234_5678};
        rst_n = 1'b0;
        drive(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b1);
        step(); step();
        check("rst_mtime", mtime0, 64'd0);
        check("rst_irq_timer", {63'd0, irqt0}, 64'd0);
        check("rst_irq_soft", {63'd0, irqs0}, 64'd0);
        drive(32'h4004, 32'd0, 4'hF, 1'b0);
        #1 check("rst_cmp_hi", {32'd0, rdata0}, 64'hFFFF_FFFF);

        // Idle count and prescale
        rst_n = 1'b1;
        step(); step(); step();
        check("div4_after3", mtime1, 64'd0);
        step();
        check("div4_after4", mtime1, 64'd1);
        step();
        check("div1_after5", mtime0, 64'd5);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check("div4_prescale_discard", mtime1, 64'd0);
        step();
        check("div4_restart", mtime1, 64'd1);

        // Timer interrupt rise and fall
        drive(32'h4004, 32'd0, 4'hF, 1'b1);  step();
        drive(32'h4000, 32'd10, 4'hF, 1'b1); step();
        drive(32'h0, 32'd0, 4'h0, 1'b0);
        n = 0;
        while (mtime0 != 64'd10 && n < 50) begin step(); n++; end
        check("mtime_reached_10", mtime0, 64'd10);
        check("irq_low_at_10", {63'd0, irqt0}, 64'd0);
        step();
        check("irq_high_at_11", {63'd0, irqt0}, 64'd1);
        drive(32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b1); step();
        check("irq_still_high", {63'd0, irqt0}, 64'd1);
        drive(32'h0, 32'd0, 4'h0, 1'b0); step();
        check("irq_fell", {63'd0, irqt0}, 64'd0);

        // Carry and wrap
        drive(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b1); step();
        drive(32'hBFFC, 32'd0, 4'hF, 1'b1);         step();
        check("carry_pre", mtime0, 64'h0000_0000_FFFF_FFFF);
        drive(32'hBFFC, 32'd0, 4'hF, 1'b0);         step();
        check("carry", mtime0, 64'h0000_0001_0000_0000);
        #1 check("carry_rd_hi", {32'd0, rdata0}, 64'd1);
        drive(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b1); step();
        drive(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b1); step();
        check("wrap_pre", mtime0, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(32'h0, 32'd0, 4'h0, 1'b0);            step();
        check("wrap", mtime0, 64'd0);

        // Strobed write on a tick cycle
        drive(32'hBFF8, 32'h100, 4'hF, 1'b1); step();
        drive(32'hBFFC, 32'd0, 4'hF, 1'b1);   step();
        drive(32'hBFF8, 32'hAABB_CCDD, 4'b0001, 1'b1);
        #1 check("strobe_pre_read", {32'd0, rdata0}, 64'h100);
        step();
        check("strobe_merge", mtime0, 64'h1DD);

        // msip, unmapped offset, write-enable low
        drive(32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1); step();
        check("msip_set", {63'd0, irqs0}, 64'd1);
        drive(32'h0, 32'd0, 4'hF, 1'b0);
        #1 check("msip_read", {32'd0, rdata0}, 64'd1);
        drive(32'h8, 32'h1234, 4'hF, 1'b1); step();
        drive(32'h8, 32'd0, 4'h0, 1'b0);
        #1 check("unmapped_read", {32'd0, rdata0}, 64'd0);
        drive(32'h4000, 32'd0, 4'hF, 1'b0); step();
        check("we_low_cmp", {32'd0, rdata0}, 64'hFFFF_FFFF);

        // Randomised traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 127) != 0);
            drive(tbl[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  4'($urandom), ($urandom_range(0, 2) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor. It is the memory-mapped responder on the LSU's CLINT port: it decodes the offset address, honours the byte-write strobe, and returns read data in the same cycle.
- Holds a free-running 64-bit mtime counter, a 64-bit mtimecmp compare register and the msip software-interrupt bit.
- Drives the machine timer and software interrupt lines into the trap/CSR logic.
- Exports mtime for the time/timeh CSRs.

Parameters:
- TICK_DIV, 1: clock cycles per mtime increment. Legal range is 1..2^16.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp. The default keeps the timer interrupt deasserted out of reset.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_addr  in  XLEN  byte offset from the CLINT base (the LSU has already subtracted the base).
- i_wdata  in  XLEN  write data, unshifted, in byte lanes selected by i_wstrb.
- i_wstrb  in  XLEN/BYTE_WIDTH  byte-write strobes.
- i_we  in  1  write enable. The LSU deasserts it when a trap is requested.
- o_rdata  out  XLEN  combinational read data.
- o_mtime  out  64  current mtime register value.
- o_irq_timer  out  1  machine timer interrupt pending (MTIP).
- o_irq_soft  out  1  machine software interrupt pending (MSIP).

Behaviour:
- Register map. Decode is on word offset i_addr[XLEN-1:2]; i_addr[1:0] is ignored.
  - 0x0000 msip: bit 0 is RW, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset reads 0 and ignores writes. No error is signalled; access faults are the LSU's concern.
- Reads:
  - o_rdata is purely combinational from i_addr and the current register state, with zero latency.
  - A read in the cycle of a write returns the pre-write value.
- Writes:
  - Happen at the clock edge when i_we=1.
  - Each byte lane k is updated only if i_wstrb[k]=1; lane k of the register takes i_wdata[8k+7:8k]. Unstrobed lanes keep their value.
  - msip: only bit 0 of lane 0 is stored.
- Prescaler:
  - A tick counter counts 0..TICK_DIV-1 every cycle and wraps to 0.
  - A tick is asserted when the counter equals TICK_DIV-1. With TICK_DIV=1 a tick occurs every cycle.
  - The prescaler is not affected by mtime writes.
- mtime increment:
  - On a tick, mtime <= mtime + 1 as a 64-bit add, with carry from the low word into the high word.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Write vs. tick in the same cycle:
  - If a write targets either mtime word in a tick cycle, the write takes precedence for the whole 64-bit register: the increment is suppressed for that cycle.
  - The new value is the byte-merged pre-increment value.
- Timer interrupt:
  - o_irq_timer is registered. Each cycle, o_irq_timer <= (mtime >= mtimecmp), an unsigned 64-bit compare using the current-cycle register values, i.e. before this edge's updates.
  - It therefore reflects register changes with 1 cycle of latency.
  - It is level-sensitive: it clears only when mtimecmp is raised above mtime, or mtime is rewritten below mtimecmp.
- o_irq_soft equals msip[0] directly (a registered bit).
- o_mtime equals the mtime register directly.
- Reset, when i_rst_n=0 at an edge, overrides any write or tick in that cycle:
  - mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler=0.
  - o_irq_timer=0, o_irq_soft=0.
  - Reset mid-count discards the partial prescale.
- Non-atomic 64-bit updates (two 32-bit writes) are software's responsibility. Hardware performs no shadowing or locking.

Test Plan:
- Reset and idle count:
  - Assert i_rst_n=0 for 2 cycles with i_we=1 writing 0xBFF8 -> mtime=0, o_irq_timer=0, o_irq_soft=0, o_rdata@0x4004=0xFFFFFFFF.
  - After release with TICK_DIV=1, o_mtime=N after N cycles.
- Prescale:
  - TICK_DIV=4, reset released -> o_mtime increments every 4th cycle (0,0,0,1,1,1,1,2...).
  - Reasserting reset after 2 cycles of a prescale period -> next increment occurs 4 cycles after release.
- Timer interrupt:
  - Write mtimecmp hi=0, then lo=10 -> o_irq_timer rises exactly 1 cycle after mtime reaches 10.
  - Writing mtimecmp lo=0xFFFF_FFFF -> o_irq_timer falls 1 cycle later.
- Carry and wrap:
  - Write mtime lo=0xFFFF_FFFF, hi=0 -> next tick gives hi=1, lo=0.
  - Write both words to all-ones -> next tick gives 0.
- Strobes and simultaneous events:
  - Write i_addr=0xBFF8, i_wdata=0xAABB_CCDD, i_wstrb=4'b0001 on a tick cycle with mtime=0x100 -> mtime=0x1DD (no increment); o_rdata read in that cycle is 0x100.
- msip and unmapped:
  - Write 0x0000 with 0xFFFF_FFFF -> o_irq_soft=1 next cycle; read returns 0x1.
  - Write 0x0008 with 0x1234 -> no state change; read 0x0008 returns 0.
  - i_we=0 with i_wstrb=4'b1111 -> no write.
